pattern_sequencer: RTL and testbench
====================================

# pattern_sequencer

Video timing and pattern-mode controller that drives the test-pattern colour generator. Generates the raster counters (HCNT/VCNT), sync and data-enable strobes, and the 2-bit pattern `mode`, advancing `mode` from a pushbutton or automatically every N frames. Mode changes only at frame boundaries, so a frame never mixes patterns. The colour generator registers its output, so the top level delays `hsync`/`vsync`/`de` by one cycle to re-align them with the pixels.

## Interface
- `active_h`, 1920, visible pixels per line
- `fp_h`, 88, horizontal front porch (clocks)
- `sync_h`, 44, horizontal sync width
- `total_h`, 2200, clocks per line
- `active_v`, 1080, visible lines per frame
- `fp_v`, 4, vertical front porch (lines)
- `sync_v`, 5, vertical sync width
- `total_v`, 1125, lines per frame
- `frames_per_mode`, 60, frames per pattern in auto mode (≥1)
- `debounce_cycles`, 1000000, stable-low clocks required to accept a press (only with `PATTERN_DEBOUNCE_EN`)

- `clk` in 1: pixel clock
- `reset` in 1: asynchronous, active-high reset
- `btn` in 1: raw pushbutton, active-low, asynchronous to `clk`
- `auto` in 1: level; 1 = auto-advance every `frames_per_mode` frames
- `HCNT` out 12: horizontal counter, 0..total_h-1
- `VCNT` out 12: vertical counter, 0..total_v-1
- `hsync` out 1: active-high horizontal sync
- `vsync` out 1: active-high vertical sync
- `de` out 1: active-video enable
- `mode` out 2: pattern select for the colour generator
- `frame_start` out 1: one-cycle pulse at HCNT=0, VCNT=0

## Operation
- Raster: HCNT increments every clock and wraps total_h-1→0. VCNT increments when HCNT wraps and itself wraps total_v-1→0.
- `de` = (HCNT < active_h) && (VCNT < active_v).
- `hsync` = 1 for HCNT in [active_h+fp_h, active_h+fp_h+sync_h).
- `vsync` = 1 for VCNT in [active_v+fp_v, active_v+fp_v+sync_v), for whole lines.
- Frame end (FE) = HCNT==total_h-1 && VCNT==total_v-1.
- Button path: 2-flop synchronizer, then falling-edge detect. A detected press sets `pend`. Further presses while `pend` is set are absorbed.
- Frame counter `fcnt` (≥ clog2(frames_per_mode) bits) increments at each FE while `auto`=1. When `auto`=0 it holds at 0.
- At FE, mode advances (mode+1, wraps 3→0) if `pend`, or if `auto` && fcnt==frames_per_mode-1. On advance, both `pend` and `fcnt` clear.
- Press and auto terminal at the same FE: advance exactly once.
- Press detected in the same cycle as FE: it is not applied at that FE. It stays pending for the next FE.
- `auto` deasserted mid-count: `fcnt` clears at the next clock. A pending press is still honoured.
- States (`pend` × `auto`): IDLE, PENDING, AUTO_COUNT, AUTO_PENDING. The only exit to the mode update is FE.

## Timing
- All outputs are registered. HCNT, VCNT, hsync, vsync, de and frame_start describe the same pixel in the same cycle.
- Reset values: HCNT=0, VCNT=0, mode=0, de=0, hsync=0, vsync=0, frame_start=0; internal pend=0, fcnt=0, synchronizer flops=1.
- First cycle after reset release: HCNT=0, VCNT=0, de=0. Second cycle: HCNT=1, de=1.
- `frame_start` pulses every frame starting with the first wrap, not directly after reset.
- `mode` changes in the cycle where HCNT=0, VCNT=0, together with `frame_start`.
- Press latency: btn low → `pend` set after 3 clocks, or 3 + debounce_cycles with debounce enabled. Mode updates at the following FE.
- Reset asserted mid-frame: everything returns to reset values immediately. A pending press is discarded.

## Configuration
- `PATTERN_DEBOUNCE_EN` defined: after the synchronizer, a counter requires `btn` stable low for `debounce_cycles` consecutive clocks before registering one press. The counter restarts on any high sample. `btn` must return high before another press is accepted.
- Not defined: a synchronized falling edge registers immediately. `debounce_cycles` is unused.

## Test plan
Bench parameters: active_h=8, fp_h=1, sync_h=2, total_h=12, active_v=4, fp_v=1, sync_v=1, total_v=7, frames_per_mode=3, debounce_cycles=4.
- Reset, run 84 clocks → HCNT wraps 11→0 and VCNT 6→0; hsync high at HCNT 9–10; vsync high on VCNT 5; de high for HCNT<8 && VCNT<4; one frame_start per 84 clocks.
- auto=1, btn high → mode steps 0→1→2→3→0 at every 3rd frame_start; no change at other frames.
- auto=0, btn pulsed low for 20 clocks mid-frame → mode 0→1 exactly at the next frame_start, and only once.
- btn press that becomes pending in the same frame as the auto terminal FE → mode advances by one only; fcnt restarts, so the next auto advance comes 3 frames later.
- With PATTERN_DEBOUNCE_EN: 3-clock low glitch → no change; 10-clock low → one advance. Without the macro, the 3-clock glitch → one advance.
- reset pulsed while pend=1 and mode=2 → mode=0, HCNT=VCNT=0; no advance at the next FE.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Video raster timing plus frame-aligned pattern-mode sequencing (button or auto every N frames).
// Latency: all outputs registered and mutually aligned; press reaches pend 3 clocks after btn falls (+debounce_cycles with PATTERN_DEBOUNCE_EN).
// Backpressure: none, free-running pixel-rate stream; extra presses while one is pending are absorbed.
module pattern_sequencer #(
    parameter int active_h        = 1920,
    parameter int fp_h            = 88,
    parameter int sync_h          = 44,
    parameter int total_h         = 2200,
    parameter int active_v        = 1080,
    parameter int fp_v            = 4,
    parameter int sync_v          = 5,
    parameter int total_v         = 1125,
    parameter int frames_per_mode = 60,
    parameter int debounce_cycles = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn,
    input  logic        auto,
    output logic [11:0] HCNT,
    output logic [11:0] VCNT,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [1:0]  mode,
    output logic        frame_start
);

    localparam int HS_BEGIN = active_h + fp_h;
    localparam int HS_END   = HS_BEGIN + sync_h;
    localparam int VS_BEGIN = active_v + fp_v;
    localparam int VS_END   = VS_BEGIN + sync_v;
    localparam int FW       = (frames_per_mode > 1) ? $clog2(frames_per_mode) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        AUTO_COUNT,
        AUTO_PENDING
    } state_t;

    state_t        state;
    logic [FW-1:0] fcnt;
    logic [11:0]   h_nxt;
    logic [11:0]   v_nxt;
    logic          line_end;
    logic          fe;
    logic          sync1;
    logic          sync2;
    logic          press;
    logic          pend;
    logic          pend_nxt;
    logic          auto_term;
    logic          adv;

    // Outputs are computed from the next counter values so every registered
    // strobe describes the same pixel as the registered HCNT/VCNT.
    always_comb begin
        line_end = (HCNT == 12'(total_h - 1));
        fe       = line_end && (VCNT == 12'(total_v - 1));
        h_nxt    = line_end ? 12'd0 : HCNT + 12'd1;
        v_nxt    = VCNT;
        if (line_end) begin
            v_nxt = (VCNT == 12'(total_v - 1)) ? 12'd0 : VCNT + 12'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HCNT        <= 12'd0;
            VCNT        <= 12'd0;
            de          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            HCNT        <= h_nxt;
            VCNT        <= v_nxt;
            de          <= (h_nxt < 12'(active_h)) && (v_nxt < 12'(active_v));
            hsync       <= (h_nxt >= 12'(HS_BEGIN)) && (h_nxt < 12'(HS_END));
            vsync       <= (v_nxt >= 12'(VS_BEGIN)) && (v_nxt < 12'(VS_END));
            frame_start <= fe;
        end
    end

    // btn idles high, so the synchronizer resets to 1 to avoid a false press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef PATTERN_DEBOUNCE_EN
    localparam int DW = $clog2(debounce_cycles + 1);

    logic [DW-1:0] db_cnt;
    logic          db_done;

    // db_done blocks re-triggering until btn has been released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt  <= '0;
            db_done <= 1'b0;
        end else if (sync2) begin
            db_cnt  <= '0;
            db_done <= 1'b0;
        end else if (!db_done) begin
            if (db_cnt == DW'(debounce_cycles)) begin
                db_done <= 1'b1;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign press = !sync2 && !db_done && (db_cnt == DW'(debounce_cycles));
`else
    logic sync3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync3 <= 1'b1;
        end else begin
            sync3 <= sync2;
        end
    end

    assign press = sync3 && !sync2;
`endif

    assign pend      = (state == PENDING) || (state == AUTO_PENDING);
    assign auto_term = auto && (fcnt == FW'(frames_per_mode - 1));
    assign adv       = fe && (pend || auto_term);

    // A press arriving on the advancing FE is kept only if it is not the one
    // being consumed; otherwise it is absorbed like any duplicate press.
    always_comb begin
        if (adv) begin
            pend_nxt = press && !pend;
        end else begin
            pend_nxt = pend || press;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            fcnt  <= '0;
            mode  <= 2'd0;
        end else begin
            if (auto) begin
                state <= pend_nxt ? AUTO_PENDING : AUTO_COUNT;
            end else begin
                state <= pend_nxt ? PENDING : IDLE;
            end

            if (!auto || adv) begin
                fcnt <= '0;
            end else if (fe) begin
                fcnt <= fcnt + 1'b1;
            end

            if (adv) begin
                mode <= mode + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: raster vector table plus a frame-start mode scoreboard.
module tb_pattern_sequencer;

    localparam int AH = 8;
    localparam int TH = 12;
    localparam int TV = 7;
    localparam int FRAME = TH * TV;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn;
    logic        auto;
    logic [11:0] HCNT;
    logic [11:0] VCNT;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [1:0]  mode;
    logic        frame_start;

    pattern_sequencer #(
        .active_h(8), .fp_h(1), .sync_h(2), .total_h(12),
        .active_v(4), .fp_v(1), .sync_v(1), .total_v(7),
        .frames_per_mode(3), .debounce_cycles(4)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .auto(auto),
        .HCNT(HCNT), .VCNT(VCNT), .hsync(hsync), .vsync(vsync),
        .de(de), .mode(mode), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        int          cyc;
        logic [11:0] h;
        logic [11:0] v;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
    } vec_t;

    vec_t       tbl[16];
    logic [1:0] q[$];
    logic [1:0] exp_last;
    logic [1:0] prev_mode;
    logic       mid_change;
    int         nfs;
    int         cur;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Every cycle advances through here so the mode scoreboard sees each frame_start.
    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            if (frame_start) begin
                if (q.size() > 0) exp_last = q.pop_front();
                check("mode_at_frame_start", 32'(mode), 32'(exp_last));
                check("frame_start_pos", 32'({HCNT, VCNT}), 32'd0);
                check("mode_stable_midframe", 32'(mid_change), 32'd0);
                mid_change = 1'b0;
                nfs++;
            end else if (mode !== prev_mode) begin
                mid_change = 1'b1;
            end
            prev_mode = mode;
        end
    endtask

    task automatic press(input int n);
        btn = 1'b0;
        repeat (n) tick();
        btn = 1'b1;
    endtask

    task automatic wait_fs(input int k);
        int target = nfs + k;
        int budget = k * FRAME + 200;
        while (nfs < target && budget > 0) begin
            tick();
            budget--;
        end
        check("frame_start_timeout", 32'(nfs), 32'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] got_v;
        logic [27:0] exp_v;
        int          h_e;
        int          v_e;

        reset      = 1'b1;
        btn        = 1'b1;
        auto       = 1'b0;
        exp_last   = 2'd0;
        prev_mode  = 2'd0;
        mid_change = 1'b0;
        nfs        = 0;

        //         cyc   h      v     hs    vs    de    fs
        tbl[0]  = '{0,  12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1,  12'd1, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{7,  12'd7, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{8,  12'd8, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{9,  12'd9, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{10, 12'd10, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{11, 12'd11, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{12, 12'd0, 12'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{47, 12'd11, 12'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{48, 12'd0, 12'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{60, 12'd0, 12'd5, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{69, 12'd9, 12'd5, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{72, 12'd0, 12'd6, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{83, 12'd11, 12'd6, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{84, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{85, 12'd1, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_mode", 32'(mode), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            while (cyc < tbl[i].cyc) tick();
            got_v = {HCNT, VCNT, hsync, vsync, de, frame_start};
            exp_v = {tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].fs};
            check($sformatf("raster_vec_%0d", i), 32'(got_v), 32'(exp_v));
        end

        // Two further frames against the closed-form raster.
        repeat (2 * FRAME) begin
            tick();
            h_e   = cyc % TH;
            v_e   = (cyc / TH) % TV;
            exp_v = {12'(h_e), 12'(v_e), (h_e >= 9 && h_e < 11), (v_e == 5),
                     (h_e < AH && v_e < 4), (cyc % FRAME == 0)};
            got_v = {HCNT, VCNT, hsync, vsync, de, frame_start};
            check($sformatf("raster_cyc_%0d", cyc), 32'(got_v), 32'(exp_v));
        end

        // Auto advance every third frame.
        repeat (10) tick();
        auto = 1'b1;
        q.push_back(2'd0); q.push_back(2'd0); q.push_back(2'd1);
        q.push_back(2'd1); q.push_back(2'd1); q.push_back(2'd2);
        q.push_back(2'd2); q.push_back(2'd2); q.push_back(2'd3);
        q.push_back(2'd3); q.push_back(2'd3); q.push_back(2'd0);
        wait_fs(12);
        check("auto_queue_drained", 32'(q.size()), 32'd0);
        repeat (10) tick();
        auto = 1'b0;

        // Manual press mid-frame: exactly one advance at the next frame start.
        q.push_back(2'd1); q.push_back(2'd1); q.push_back(2'd1);
        press(20);
        wait_fs(3);
        check("press_queue_drained", 32'(q.size()), 32'd0);

        // Press pending in the frame that ends on the auto terminal FE.
        repeat (10) tick();
        auto = 1'b1;
        q.push_back(2'd1); q.push_back(2'd1); q.push_back(2'd2);
        q.push_back(2'd2); q.push_back(2'd2); q.push_back(2'd3);
        wait_fs(2);
        repeat (10) tick();
        press(20);
        wait_fs(4);
        check("coincide_queue_drained", 32'(q.size()), 32'd0);
        repeat (10) tick();
        auto = 1'b0;

        // Short glitch, then a long press.
`ifdef PATTERN_DEBOUNCE_EN
        q.push_back(2'd3); q.push_back(2'd3);
        press(3);
        wait_fs(2);
        repeat (10) tick();
        q.push_back(2'd0); q.push_back(2'd0);
        press(10);
        wait_fs(2);
        cur = 0;
`else
        q.push_back(2'd0); q.push_back(2'd0);
        press(3);
        wait_fs(2);
        repeat (10) tick();
        q.push_back(2'd1); q.push_back(2'd1);
        press(10);
        wait_fs(2);
        cur = 1;
`endif
        check("glitch_queue_drained", 32'(q.size()), 32'd0);

        // Bring mode to 2, leave a press pending, then reset mid-frame.
        while (cur != 2) begin
            repeat (10) tick();
            cur = (cur + 1) % 4;
            q.push_back(2'(cur));
            press(10);
            wait_fs(1);
        end
        repeat (10) tick();
        press(10);
        repeat (10) tick();
        reset = 1'b1;
        #1;
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_counters", 32'({HCNT, VCNT}), 32'd0);
        check("rst_strobes", 32'({hsync, vsync, de, frame_start}), 32'd0);
        q.delete();
        exp_last   = 2'd0;
        prev_mode  = 2'd0;
        mid_change = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        q.push_back(2'd0); q.push_back(2'd0);
        wait_fs(2);
        check("post_reset_queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
